alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
// Request-side driver for the 32-bit combinational ALU: accepts one MIPS R-type op per valid/ready
// handshake, decodes funct into ALU select bits {s0,s1,s2}, drives registered ALU operands, waits
// WAIT_CYC settle cycles, captures result/flags and returns them on a valid/ready response channel.
// Sits between the decode stage and the ALU in the multi-cycle datapath.
// PARAMETERS
// WAIT_CYC  1  ALU settle cycles in EXEC before capture (legal 1..15)
// PORTS
// clk           in   1   clock, rising edge
// rst_n         in   1   asynchronous active-low reset
// req_valid     in   1   request present
// req_ready     out  1   block can accept (high only in IDLE)
// req_funct     in   6   MIPS funct field
// req_a         in   32  rs operand
// req_b         in   32  rt operand
// req_shamt     in   5   shift amount
// alu_a         out  32  ALU operand a (registered)
// alu_b         out  32  ALU operand b (registered)
// alu_s0/s1/s2  out  1   ALU select; s0 is MSB and doubles as ALU carry-in
// alu_res       in   32  ALU result
// alu_cout_sub  in   1   ALU subtract carry-out (1 = no borrow)
// rsp_valid     out  1   response present
// rsp_ready     in   1   consumer accepts response
// rsp_res       out  32  result
// rsp_zero      out  1   rsp_res == 0
// rsp_ovf       out  1   signed overflow (add/sub only)
// rsp_err       out  1   illegal funct
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, all outputs 0, alu_s* = 000, counter 0.
// - Select code {s0,s1,s2}: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SUB, 101 SRA, 110 SLL, 111 NOR.
// - Decode: 20/21 ADD; 22/23 SUB; 24 AND; 25 OR; 26 XOR; 27 NOR; 2A/2B SUB (slt/sltu); 00 SLL;
//   03 SRA; any other funct -> illegal. ALU shifts alu_a by alu_b[4:0].
// - Operands: ALU ops alu_a=req_a, alu_b=req_b; shifts alu_a=req_b, alu_b={27'b0,req_shamt}.
// - FSM IDLE: req_ready=1. On req_valid: legal -> load alu_*, cnt=WAIT_CYC-1, go EXEC;
//   illegal -> rsp_err=1, rsp_res=0, rsp_zero=1, rsp_ovf=0, go RESP (alu_* unchanged).
// - EXEC: alu_* held stable; cnt decrements each cycle; at cnt==0 capture on that edge, go RESP.
//   Capture: slt  -> res = (a[31]^b[31]) ? {31'b0,a[31]} : {31'b0,alu_res[31]};
//            sltu -> res = {31'b0,~alu_cout_sub}; others -> res = alu_res.
//   ovf: add = a[31]==b[31] && res[31]!=a[31]; sub(0x22 only) = a[31]!=b[31] && res[31]!=a[31];
//   addu/subu/others ovf=0. zero = (res==0). err=0.
// - RESP: rsp_valid=1, rsp_* stable until rsp_ready; on handshake rsp_valid drops next edge, go IDLE.
// - Latency: accept edge t -> rsp_valid high after edge t+WAIT_CYC; illegal: after edge t+1.
//   Throughput 1 op per WAIT_CYC+2 cycles with rsp_ready held high.
// - alu_* outputs keep last driven value in IDLE/RESP; never change during EXEC.
// - Request data ignored while req_ready=0; no queueing.
// - rst_n asserted mid-EXEC/RESP: op discarded, no response, outputs return to reset values.
// TESTING
// - add 0x20: a=7FFFFFFF b=1, WAIT_CYC=1 -> alu_s=010, rsp after 1 cycle res=80000000 ovf=1 zero=0.
// - slt 0x2A: a=FFFFFFFF b=1 -> alu_s=100, res=1; sltu 0x2B same operands -> res=0.
// - sll 0x00: b=00000003 shamt=4 -> alu_a=3 alu_b=4 alu_s=110, res=00000030.
// - illegal funct 0x3F -> rsp_err=1 res=0 zero=1 one cycle after accept, alu_* unchanged.
// - rsp_ready low 5 cycles after sub a=b=5 -> rsp held res=0 zero=1, req_ready=0 throughout.
// - rst_n low mid-EXEC (WAIT_CYC=4) -> all outputs 0 asynchronously, no rsp_valid afterwards.

Source files
------------

// File: rtl/alu_issue_if.sv
// Request/response and ALU-side bundle for alu_issue_ctrl.
// slave: issue controller side; master: decode stage, ALU and consumer side.
interface alu_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_shamt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_s0;
    logic        alu_s1;
    logic        alu_s2;
    logic [31:0] alu_res;
    logic        alu_cout_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_funct, req_a, req_b, req_shamt,
        input  alu_res, alu_cout_sub, rsp_ready,
        output req_ready, alu_a, alu_b, alu_s0, alu_s1, alu_s2,
        output rsp_valid, rsp_res, rsp_zero, rsp_ovf, rsp_err
    );

    modport master (
        output req_valid, req_funct, req_a, req_b, req_shamt,
        output alu_res, alu_cout_sub, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_s0, alu_s1, alu_s2,
        input  rsp_valid, rsp_res, rsp_zero, rsp_ovf, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one MIPS R-type op to the combinational ALU, waits WAIT_CYC settle
// cycles, captures result/flags. Ports: clk, rst_n, bus (alu_issue_if.slave).
module alu_issue_ctrl #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXEC, ERR, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [5:0]  funct_q;

    logic        legal;
    logic        is_shift;
    logic [2:0]  sel;
    logic [31:0] cap_res;
    logic        cap_ovf;
    logic        a31;
    logic        b31;

    always_comb begin
        legal = 1'b1;
        sel   = 3'b000;
        case (bus.req_funct)
            6'h20, 6'h21: sel = 3'b010;
            6'h22, 6'h23,
            6'h2A, 6'h2B: sel = 3'b100;
            6'h24:        sel = 3'b000;
            6'h25:        sel = 3'b001;
            6'h26:        sel = 3'b011;
            6'h27:        sel = 3'b111;
            6'h00:        sel = 3'b110;
            6'h03:        sel = 3'b101;
            default:      legal = 1'b0;
        endcase
    end

    assign is_shift = (bus.req_funct == 6'h00) || (bus.req_funct == 6'h03);

    assign a31 = bus.alu_a[31];
    assign b31 = bus.alu_b[31];

    // slt uses the sign of a-b only when signs agree; otherwise a's sign decides.
    always_comb begin
        cap_res = bus.alu_res;
        case (funct_q)
            6'h2A: cap_res = (a31 ^ b31) ? {31'b0, a31}
                                         : {31'b0, bus.alu_res[31]};
            6'h2B: cap_res = {31'b0, ~bus.alu_cout_sub};
            default: ;
        endcase
        cap_ovf = 1'b0;
        case (funct_q)
            6'h20: cap_ovf = (a31 == b31) && (cap_res[31] != a31);
            6'h22: cap_ovf = (a31 != b31) && (cap_res[31] != a31);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            funct_q       <= '0;
            bus.req_ready <= 1'b0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_s0    <= 1'b0;
            bus.alu_s1    <= 1'b0;
            bus.alu_s2    <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_res   <= '0;
            bus.rsp_zero  <= 1'b0;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        if (legal) begin
                            bus.alu_a <= is_shift ? bus.req_b : bus.req_a;
                            bus.alu_b <= is_shift ? {27'b0, bus.req_shamt}
                                                  : bus.req_b;
                            {bus.alu_s0, bus.alu_s1, bus.alu_s2} <= sel;
                            funct_q <= bus.req_funct;
                            cnt     <= CNT_INIT;
                            state   <= EXEC;
                        end else begin
                            bus.rsp_err  <= 1'b1;
                            bus.rsp_res  <= '0;
                            bus.rsp_zero <= 1'b1;
                            bus.rsp_ovf  <= 1'b0;
                            state        <= ERR;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        bus.rsp_res   <= cap_res;
                        bus.rsp_zero  <= (cap_res == 32'd0);
                        bus.rsp_ovf   <= cap_ovf;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                // One-cycle gap so illegal ops answer one edge after accept.
                ERR: begin
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table, random ops against a
// golden model, scoreboard queue, and a WAIT_CYC=4 reset sequence.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if b1();
    alu_issue_if b4();

    alu_issue_ctrl #(.WAIT_CYC(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave)
    );
    alu_issue_ctrl #(.WAIT_CYC(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave)
    );

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        int          hold;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        err;
        logic [2:0]  sel;
    } vec_t;

    vec_t tbl[17];
    vec_t sb[$];

    int errors = 0;
    int checks = 0;

    logic [31:0] last_a   = '0;
    logic [31:0] last_b   = '0;
    logic [2:0]  last_sel = '0;

    function automatic logic [32:0] alu_model(
        input logic [2:0] s, input logic [31:0] a, input logic [31:0] b
    );
        logic [32:0] d;
        logic [31:0] r;
        d = {1'b0, a} + {1'b0, ~b} + 33'd1;
        case (s)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a + b;
            3'b011:  r = a ^ b;
            3'b100:  r = d[31:0];
            3'b101:  r = 32'($signed(a) >>> b[4:0]);
            3'b110:  r = a << b[4:0];
            default: r = ~(a | b);
        endcase
        return {d[32], r};
    endfunction

    always_comb {b1.alu_cout_sub, b1.alu_res} =
        alu_model({b1.alu_s0, b1.alu_s1, b1.alu_s2}, b1.alu_a, b1.alu_b);
    always_comb {b4.alu_cout_sub, b4.alu_res} =
        alu_model({b4.alu_s0, b4.alu_s1, b4.alu_s2}, b4.alu_a, b4.alu_b);

    function automatic vec_t gold(
        input logic [5:0] f, input logic [31:0] a,
        input logic [31:0] b, input logic [4:0] sh
    );
        vec_t v;
        v.f = f; v.a = a; v.b = b; v.sh = sh; v.hold = 0;
        v.err = 1'b0; v.ovf = 1'b0; v.sel = 3'b000; v.res = '0;
        case (f)
            6'h20: begin
                v.res = a + b; v.sel = 3'b010;
                v.ovf = (a[31] == b[31]) && (v.res[31] != a[31]);
            end
            6'h21: begin v.res = a + b; v.sel = 3'b010; end
            6'h22: begin
                v.res = a - b; v.sel = 3'b100;
                v.ovf = (a[31] != b[31]) && (v.res[31] != a[31]);
            end
            6'h23: begin v.res = a - b; v.sel = 3'b100; end
            6'h2A: begin
                v.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                v.sel = 3'b100;
            end
            6'h2B: begin v.res = (a < b) ? 32'd1 : 32'd0; v.sel = 3'b100; end
            6'h24: begin v.res = a & b; v.sel = 3'b000; end
            6'h25: begin v.res = a | b; v.sel = 3'b001; end
            6'h26: begin v.res = a ^ b; v.sel = 3'b011; end
            6'h27: begin v.res = ~(a | b); v.sel = 3'b111; end
            6'h00: begin v.res = b << sh; v.sel = 3'b110; end
            6'h03: begin v.res = 32'($signed(b) >>> sh); v.sel = 3'b101; end
            default: v.err = 1'b1;
        endcase
        v.zero = (v.res == 32'd0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run1(input vec_t v);
        int   n;
        vec_t e;
        logic sh_op;
        @(negedge clk);
        chk("req_ready_idle", 64'(b1.req_ready), 64'd1);
        b1.req_valid = 1'b1;
        b1.req_funct = v.f;
        b1.req_a     = v.a;
        b1.req_b     = v.b;
        b1.req_shamt = v.sh;
        @(posedge clk);
        sb.push_back(v);
        #1;
        b1.req_valid = 1'b0;
        b1.req_funct = 6'h3F;
        b1.req_a     = $urandom;
        b1.req_b     = $urandom;
        @(negedge clk);
        if (!v.err) begin
            sh_op    = (v.f == 6'h00) || (v.f == 6'h03);
            last_a   = sh_op ? v.b : v.a;
            last_b   = sh_op ? {27'b0, v.sh} : v.b;
            last_sel = v.sel;
        end
        chk("alu_a", 64'(b1.alu_a), 64'(last_a));
        chk("alu_b", 64'(b1.alu_b), 64'(last_b));
        chk("alu_sel", 64'({b1.alu_s0, b1.alu_s1, b1.alu_s2}), 64'(last_sel));
        n = 1;
        while (!b1.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'd2);
        for (int i = 0; i < v.hold; i++) begin
            chk("hold", 64'({b1.rsp_valid, b1.req_ready, b1.rsp_zero, b1.rsp_res}),
                64'({1'b1, 1'b0, v.zero, v.res}));
            @(negedge clk);
        end
        b1.rsp_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("rsp_res", 64'(b1.rsp_res), 64'(e.res));
            chk("rsp_flags", 64'({b1.rsp_valid, b1.rsp_zero, b1.rsp_ovf, b1.rsp_err}),
                64'({1'b1, e.zero, e.ovf, e.err}));
        end
        @(posedge clk);
        #1 b1.rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_drop", 64'({b1.rsp_valid, b1.req_ready}), 64'(2'b01));
    endtask

    int   n4;
    int   seen;
    vec_t rv;
    logic [5:0] fl [14];

    initial begin
        tbl[0]  = '{6'h20, 32'h7FFFFFFF, 32'h00000001, 5'd0, 0, 32'h80000000, 1'b0, 1'b1, 1'b0, 3'b010};
        tbl[1]  = '{6'h2A, 32'hFFFFFFFF, 32'h00000001, 5'd0, 0, 32'h00000001, 1'b0, 1'b0, 1'b0, 3'b100};
        tbl[2]  = '{6'h2B, 32'hFFFFFFFF, 32'h00000001, 5'd0, 0, 32'h00000000, 1'b1, 1'b0, 1'b0, 3'b100};
        tbl[3]  = '{6'h00, 32'hDEADBEEF, 32'h00000003, 5'd4, 0, 32'h00000030, 1'b0, 1'b0, 1'b0, 3'b110};
        tbl[4]  = '{6'h3F, 32'h12345678, 32'h9ABCDEF0, 5'd7, 0, 32'h00000000, 1'b1, 1'b0, 1'b1, 3'b000};
        tbl[5]  = '{6'h22, 32'h00000005, 32'h00000005, 5'd0, 5, 32'h00000000, 1'b1, 1'b0, 1'b0, 3'b100};
        tbl[6]  = '{6'h22, 32'h80000000, 32'h00000001, 5'd0, 0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 3'b100};
        tbl[7]  = '{6'h21, 32'h7FFFFFFF, 32'h00000001, 5'd0, 0, 32'h80000000, 1'b0, 1'b0, 1'b0, 3'b010};
        tbl[8]  = '{6'h03, 32'h0, 32'h80000000, 5'd4, 0, 32'hF8000000, 1'b0, 1'b0, 1'b0, 3'b101};
        tbl[9]  = '{6'h27, 32'h0, 32'h0, 5'd0, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 3'b111};
        tbl[10] = '{6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 3'b011};
        tbl[11] = '{6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 0, 32'hF000F000, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[12] = '{6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 2, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 3'b001};
        tbl[13] = '{6'h23, 32'h00000000, 32'h00000001, 5'd0, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 3'b100};
        tbl[14] = '{6'h2A, 32'h00000001, 32'hFFFFFFFF, 5'd0, 0, 32'h00000000, 1'b1, 1'b0, 1'b0, 3'b100};
        tbl[15] = '{6'h2A, 32'h00000003, 32'h00000005, 5'd0, 0, 32'h00000001, 1'b0, 1'b0, 1'b0, 3'b100};
        tbl[16] = '{6'h01, 32'h00000001, 32'h00000001, 5'd0, 0, 32'h00000000, 1'b1, 1'b0, 1'b1, 3'b000};

        fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
               6'h27, 6'h2A, 6'h2B, 6'h00, 6'h03, 6'h3F, 6'h10};

        b1.req_valid = 1'b0; b1.req_funct = '0; b1.req_a = '0;
        b1.req_b = '0; b1.req_shamt = '0; b1.rsp_ready = 1'b0;
        b4.req_valid = 1'b0; b4.req_funct = '0; b4.req_a = '0;
        b4.req_b = '0; b4.req_shamt = '0; b4.rsp_ready = 1'b0;

        #1;
        chk("reset_outs", 64'({b1.req_ready, b1.alu_s0, b1.alu_s1, b1.alu_s2,
                               b1.rsp_valid, b1.rsp_zero, b1.rsp_ovf, b1.rsp_err}),
            64'd0);
        chk("reset_data", 64'(b1.alu_a | b1.alu_b | b1.rsp_res), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 17; i++) run1(tbl[i]);

        for (int i = 0; i < 20; i++) begin
            rv = gold(fl[$urandom_range(13, 0)], $urandom, $urandom,
                      5'($urandom_range(31, 0)));
            run1(rv);
        end

        // WAIT_CYC=4: latency then reset mid-EXEC
        @(negedge clk);
        b4.req_valid = 1'b1; b4.req_funct = 6'h20;
        b4.req_a = 32'd2; b4.req_b = 32'd3;
        @(posedge clk);
        #1 b4.req_valid = 1'b0;
        @(negedge clk);
        n4 = 1;
        while (!b4.rsp_valid && n4 < 20) begin
            @(negedge clk);
            n4++;
        end
        chk("w4_latency", 64'(n4), 64'd5);
        chk("w4_res", 64'(b4.rsp_res), 64'd5);
        b4.rsp_ready = 1'b1;
        @(posedge clk);
        #1 b4.rsp_ready = 1'b0;

        @(negedge clk);
        b4.req_valid = 1'b1; b4.req_funct = 6'h22;
        b4.req_a = 32'd9; b4.req_b = 32'd4;
        @(posedge clk);
        #1 b4.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("w4_exec_a", 64'(b4.alu_a), 64'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("w4_rst_outs", 64'({b4.req_ready, b4.alu_s0, b4.alu_s1, b4.alu_s2,
                                b4.rsp_valid, b4.rsp_zero, b4.rsp_ovf, b4.rsp_err}),
            64'd0);
        chk("w4_rst_data", 64'(b4.alu_a | b4.alu_b | b4.rsp_res), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b4.rsp_valid) seen++;
        end
        chk("w4_no_rsp", 64'(seen), 64'd0);
        chk("w4_ready_back", 64'(b4.req_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
